// File: rtl/alu_arbiter.sv
// Two-port valid/ready arbiter that sequences requests through one shared alu_8bit.
// Build option: define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.

`ifndef WORD
`define WORD 8
`endif
`ifndef OP_SUM
`define OP_SUM 3'b000
`endif
`ifndef OP_SUB
`define OP_SUB 3'b001
`endif
`ifndef OP_AND
`define OP_AND 3'b010
`endif
`ifndef OP_XOR
`define OP_XOR 3'b011
`endif

module alu_8bit #(
   parameter int WIDTH = `WORD
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             cf
);

   logic [WIDTH:0] sum_ext;

   assign sum_ext = {1'b0, a} + {1'b0, b};

   always_comb begin
      result = '0;
      cf     = 1'b0;
      case (op)
         `OP_SUM: begin
            result = sum_ext[WIDTH-1:0];
            cf     = sum_ext[WIDTH];
         end
         `OP_SUB: begin
            result = a - b;
            cf     = (a < b);
         end
         `OP_AND: result = a & b;
         `OP_XOR: result = a ^ b;
         // undefined opcodes answer with a zero result
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

module alu_arbiter #(
   parameter int WIDTH = `WORD
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_req0_valid,
   output logic             o_req0_ready,
   input  logic [WIDTH-1:0] i_req0_a,
   input  logic [WIDTH-1:0] i_req0_b,
   input  logic [2:0]       i_req0_op,
   input  logic             i_req1_valid,
   output logic             o_req1_ready,
   input  logic [WIDTH-1:0] i_req1_a,
   input  logic [WIDTH-1:0] i_req1_b,
   input  logic [2:0]       i_req1_op,
   output logic             o_rsp_valid,
   input  logic             i_rsp_ready,
   output logic [WIDTH-1:0] o_rsp_result,
   output logic             o_rsp_zero,
   output logic             o_rsp_cf,
   output logic             o_rsp_id,
   output logic             o_busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t state_reg;
   state_t state_next;

   logic             req_valid [2];
   logic             req_ready [2];
   logic [WIDTH-1:0] req_a     [2];
   logic [WIDTH-1:0] req_b     [2];
   logic [2:0]       req_op    [2];

   logic             grant;
   logic             accept;
   logic             in_idle;
   logic             in_exec;
   logic             busy;

   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [2:0]       op_reg;
   logic             id_reg;

   logic [WIDTH-1:0] alu_result;
   logic             alu_zero;
   logic             alu_cf;

   logic             rsp_valid_reg;
   logic [WIDTH-1:0] rsp_result_reg;
   logic             rsp_zero_reg;
   logic             rsp_cf_reg;
   logic             rsp_id_reg;

   assign req_valid[0] = i_req0_valid;
   assign req_valid[1] = i_req1_valid;
   assign req_a[0]     = i_req0_a;
   assign req_a[1]     = i_req1_a;
   assign req_b[0]     = i_req0_b;
   assign req_b[1]     = i_req1_b;
   assign req_op[0]    = i_req0_op;
   assign req_op[1]    = i_req1_op;

`ifdef ALU_ARB_RR_EN
   logic last_grant_reg;

   // Reset to 1 so that requester 0 wins the first contention.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         last_grant_reg <= 1'b1;
      end else if (accept) begin
         last_grant_reg <= grant;
      end
   end

   always_comb begin
      grant = 1'b0;
      if (req_valid[0] && req_valid[1]) begin
         grant = ~last_grant_reg;
      end else if (req_valid[1]) begin
         grant = 1'b1;
      end
   end
`else
   always_comb begin
      grant = 1'b0;
      if (!req_valid[0] && req_valid[1]) begin
         grant = 1'b1;
      end
   end
`endif

   // Ready depends only on reset, state and the valids, never on i_rsp_ready.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_ready
         assign req_ready[gi] = i_rst_n && in_idle && req_valid[gi] && (grant == 1'(gi));
      end
   endgenerate

   assign o_req0_ready = req_ready[0];
   assign o_req1_ready = req_ready[1];
   assign accept       = req_ready[0] | req_ready[1];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (accept) state_next = ST_EXEC;
         ST_EXEC: state_next = ST_RESP;
         ST_RESP: if (rsp_valid_reg && i_rsp_ready) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      in_idle = (state_reg == ST_IDLE);
      in_exec = (state_reg == ST_EXEC);
      busy    = (state_reg != ST_IDLE);
   end

   assign o_busy = busy;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         a_reg  <= '0;
         b_reg  <= '0;
         op_reg <= '0;
         id_reg <= 1'b0;
      end else if (accept) begin
         a_reg  <= req_a[grant];
         b_reg  <= req_b[grant];
         op_reg <= req_op[grant];
         id_reg <= grant;
      end
   end

   alu_8bit #(
      .WIDTH (WIDTH)
   ) u_alu (
      .a      (a_reg),
      .b      (b_reg),
      .op     (op_reg),
      .result (alu_result),
      .zero   (alu_zero),
      .cf     (alu_cf)
   );

   // Response registers are only loaded from EXEC, so they hold through RESP.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rsp_valid_reg  <= 1'b0;
         rsp_result_reg <= '0;
         rsp_zero_reg   <= 1'b0;
         rsp_cf_reg     <= 1'b0;
         rsp_id_reg     <= 1'b0;
      end else if (in_exec) begin
         rsp_valid_reg  <= 1'b1;
         rsp_result_reg <= alu_result;
         rsp_zero_reg   <= alu_zero;
         rsp_cf_reg     <= alu_cf;
         rsp_id_reg     <= id_reg;
      end else if (rsp_valid_reg && i_rsp_ready) begin
         rsp_valid_reg  <= 1'b0;
      end
   end

   assign o_rsp_valid  = rsp_valid_reg;
   assign o_rsp_result = rsp_result_reg;
   assign o_rsp_zero   = rsp_zero_reg;
   assign o_rsp_cf     = rsp_cf_reg;
   assign o_rsp_id     = rsp_id_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed cases plus randomized traffic against a behavioural model.

`timescale 1ns/1ps

`ifndef OP_SUM
`define OP_SUM 3'b000
`endif
`ifndef OP_SUB
`define OP_SUB 3'b001
`endif
`ifndef OP_AND
`define OP_AND 3'b010
`endif
`ifndef OP_XOR
`define OP_XOR 3'b011
`endif

module tb_alu_arbiter;

`ifdef ALU_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0_valid, req1_valid;
   logic       req0_ready, req1_ready;
   logic [7:0] req0_a, req0_b, req1_a, req1_b;
   logic [2:0] req0_op, req1_op;
   logic       rsp_valid, rsp_ready;
   logic [7:0] rsp_result;
   logic       rsp_zero, rsp_cf, rsp_id, busy;

   int checks   = 0;
   int failures = 0;
   bit model_last = 1'b1;
   int last_id;

   always #5 clk = ~clk;

   alu_arbiter #(.WIDTH(8)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_req0_valid (req0_valid),
      .o_req0_ready (req0_ready),
      .i_req0_a     (req0_a),
      .i_req0_b     (req0_b),
      .i_req0_op    (req0_op),
      .i_req1_valid (req1_valid),
      .o_req1_ready (req1_ready),
      .i_req1_a     (req1_a),
      .i_req1_b     (req1_b),
      .i_req1_op    (req1_op),
      .o_rsp_valid  (rsp_valid),
      .i_rsp_ready  (rsp_ready),
      .o_rsp_result (rsp_result),
      .o_rsp_zero   (rsp_zero),
      .o_rsp_cf     (rsp_cf),
      .o_rsp_id     (rsp_id),
      .o_busy       (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Returns {zero, cf, result[7:0]} from plain integer arithmetic.
   function automatic logic [9:0] alu_model(input int a, input int b, input logic [2:0] op);
      int r;
      bit c;
      r = 0;
      c = 1'b0;
      case (op)
         `OP_SUM: begin r = a + b; c = (r > 255); r = r % 256; end
         `OP_SUB: begin c = (a < b); r = (a - b + 256) % 256; end
         `OP_AND: r = a & b;
         `OP_XOR: r = a ^ b;
         default: r = 0;
      endcase
      return {(r == 0), c, 8'(r)};
   endfunction

   // Runs one IDLE->EXEC->RESP->IDLE cycle; starts and ends at a negedge with the DUT in IDLE.
   task automatic do_op(input bit v0, input bit v1,
                        input logic [7:0] a0, input logic [7:0] b0, input logic [2:0] op0,
                        input logic [7:0] a1, input logic [7:0] b1, input logic [2:0] op1,
                        input int hold);
      bit g;
      logic [9:0] exp;
      logic [7:0] held_result;
      req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
      req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
      rsp_ready  = (hold == 0);
      #1;
      if (!v0 && !v1) begin
         chk("idle_ready0", req0_ready, 0);
         chk("idle_ready1", req1_ready, 0);
         tick();
         chk("idle_busy", busy, 0);
         last_id = -1;
         return;
      end
      if (v0 && v1) g = RR ? !model_last : 1'b0;
      else          g = v1;
      chk("ready0", req0_ready, (g == 1'b0));
      chk("ready1", req1_ready, (g == 1'b1));
      exp = g ? alu_model(a1, b1, op1) : alu_model(a0, b0, op0);
      model_last = g;
      tick();
      chk("exec_busy", busy, 1);
      chk("exec_rsp_valid", rsp_valid, 0);
      chk("exec_readies", {req0_ready, req1_ready}, 0);
      tick();
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_result", rsp_result, exp[7:0]);
      chk("rsp_cf", rsp_cf, exp[8]);
      chk("rsp_zero", rsp_zero, exp[9]);
      chk("rsp_id", rsp_id, g);
      last_id = rsp_id;
      held_result = exp[7:0];
      for (int i = 0; i < hold; i++) begin
         tick();
         chk("hold_valid", rsp_valid, 1);
         chk("hold_result", rsp_result, held_result);
         chk("hold_id", rsp_id, g);
         chk("hold_readies", {req0_ready, req1_ready}, 0);
      end
      rsp_ready = 1'b1;
      tick();
      chk("done_rsp_valid", rsp_valid, 0);
      chk("done_busy", busy, 0);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      model_last = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      int exp_ids[4];
      rst_n = 1'b0;
      req0_valid = 0; req1_valid = 0; rsp_ready = 0;
      req0_a = 0; req0_b = 0; req0_op = 0;
      req1_a = 0; req1_b = 0; req1_op = 0;
      #1;
      chk("rst_readies", {req0_ready, req1_ready}, 0);
      req0_valid = 1; req1_valid = 1;
      #1;
      chk("rst_readies_forced", {req0_ready, req1_ready}, 0);
      req0_valid = 0; req1_valid = 0;
      @(negedge clk);
      apply_reset();
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_fields", {rsp_result, rsp_zero, rsp_cf, rsp_id}, 0);

      // Directed cases from the test plan.
      do_op(1, 0, 8'hF0, 8'h20, `OP_SUM, 8'h00, 8'h00, `OP_SUM, 0);
      do_op(0, 1, 8'h00, 8'h00, `OP_SUM, 8'h05, 8'h07, `OP_SUB, 0);
      chk("sub_lt_result", rsp_result, 8'hFE);
      do_op(0, 1, 8'h00, 8'h00, `OP_SUM, 8'h07, 8'h05, `OP_SUB, 0);
      chk("sub_ge_result", rsp_result, 8'h02);
      do_op(1, 0, 8'h0F, 8'hF0, `OP_AND, 8'h00, 8'h00, `OP_SUM, 0);
      chk("and_zero", rsp_zero, 1);
      do_op(1, 0, 8'h5A, 8'h33, 3'b111, 8'h00, 8'h00, `OP_SUM, 0);
      chk("undef_result", rsp_result, 0);

      // Fresh reset so the contention sequence starts from the reset grant state.
      apply_reset();
      chk("rst2_rsp_fields", {rsp_valid, rsp_result, rsp_zero, rsp_cf, rsp_id}, 0);
      if (RR) exp_ids = '{0, 1, 0, 1};
      else    exp_ids = '{0, 0, 0, 0};
      for (int i = 0; i < 4; i++) begin
         do_op(1, 1, 8'(i + 1), 8'h10, `OP_SUM, 8'(i + 9), 8'h03, `OP_XOR, 0);
         chk("contention_id", last_id, exp_ids[i]);
      end

      // Back-pressure: response holds for 5 cycles, next request accepted right after.
      do_op(0, 1, 8'h00, 8'h00, `OP_SUM, 8'hC3, 8'h81, `OP_XOR, 5);
      do_op(1, 0, 8'h80, 8'h80, `OP_SUM, 8'h00, 8'h00, `OP_SUM, 0);

      // Valid withdrawn before its handshake edge leaves the block idle.
      req0_valid = 1; req1_valid = 0;
      #1;
      chk("withdraw_ready_up", req0_ready, 1);
      req0_valid = 0;
      #1;
      chk("withdraw_ready_down", req0_ready, 0);
      tick();
      chk("withdraw_busy", busy, 0);

      // Randomized traffic.
      for (int n = 0; n < 40; n++) begin
         do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
               8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
               int'($urandom_range(0, 2)));
      end

      // Reset during EXEC aborts the operation at once.
      req0_valid = 1; req0_a = 8'hFF; req0_b = 8'h01; req0_op = `OP_SUM;
      req1_valid = 1; rsp_ready = 1;
      tick();
      chk("abort_in_exec", busy, 1);
      rst_n = 1'b0;
      model_last = 1'b1;
      #1;
      chk("abort_rsp_valid", rsp_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_readies", {req0_ready, req1_ready}, 0);
      tick();
      chk("abort_no_rsp", rsp_valid, 0);
      rst_n = 1'b1;
      #1;
      chk("abort_first_grant0", {req0_ready, req1_ready}, 2'b10);
      do_op(1, 1, 8'h21, 8'h12, `OP_SUB, 8'h44, 8'h44, `OP_XOR, 1);
      chk("abort_first_id", last_id, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
